// File: rtl/uctl_reset_seq.sv
// Reset sequencer: synchronises ext_rst_n, stretches it, then releases NUM_RST resets in order.
// Latency: first release SYNC_STAGES+STRETCH_CYC edges after reset lifts; GAP_CYC between releases.
// Backpressure: none; optional 4-phase soft reset handshake when UCTL_RST_SEQ_SOFT_EN is defined.
module uctl_reset_seq #(
    parameter int NUM_RST     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH_CYC = 16,
    parameter int GAP_CYC     = 4,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               uctl_PoRst_n,
    input  logic               ext_rst_n,
`ifdef UCTL_RST_SEQ_SOFT_EN
    input  logic               soft_rst_req,
    output logic               soft_rst_ack,
`endif
    output logic [NUM_RST-1:0] rst_out_n,
    output logic               rst_busy,
    output logic               seq_done
);

    localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_RST - 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {ASSERT, SEQ, DONE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   ext_ok;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [NUM_RST-1:0]     rst_nxt;
    logic                   done_nxt;
    logic                   soft_trig;

    assign ext_ok   = sync[SYNC_STAGES-1];
    assign rst_busy = ~&rst_out_n;

`ifdef UCTL_RST_SEQ_SOFT_EN
    logic soft_act, soft_act_nxt;

    assign soft_trig    = soft_rst_req && !soft_act;
    assign soft_rst_ack = soft_act && (state == DONE);

    always_comb begin
        soft_act_nxt = soft_act;
        if (soft_trig)
            soft_act_nxt = 1'b1;
        else if (soft_rst_ack && !soft_rst_req)
            soft_act_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!uctl_PoRst_n)
            soft_act <= 1'b0;
        else
            soft_act <= soft_act_nxt;
    end
`else
    assign soft_trig = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        rst_nxt   = rst_out_n;
        done_nxt  = 1'b0;
        case (state)
            ASSERT: begin
                rst_nxt = '0;
                idx_nxt = '0;
                if (cnt == STRETCH_LAST) begin
                    cnt_nxt = '0;
                    // single output or zero gap: everything lets go on the stretch exit edge
                    if (NUM_RST == 1 || GAP_CYC == 0) begin
                        rst_nxt   = '1;
                        idx_nxt   = LAST_IDX;
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        rst_nxt[0] = 1'b1;
                        state_nxt  = SEQ;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SEQ: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt          = '0;
                    idx_nxt          = idx + 1'b1;
                    rst_nxt[idx_nxt] = 1'b1;
                    if (idx_nxt == LAST_IDX) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: ;
        endcase
        // losing ext_ok (or a new soft request) beats any release or done pulse
        if (!ext_ok || soft_trig) begin
            state_nxt = ASSERT;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            rst_nxt   = '0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!uctl_PoRst_n) begin
            sync      <= '0;
            state     <= ASSERT;
            cnt       <= '0;
            idx       <= '0;
            rst_out_n <= '0;
            seq_done  <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], ext_rst_n};
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            rst_out_n <= rst_nxt;
            seq_done  <= done_nxt;
        end
    end

endmodule
